// File: rtl/bool_scan_pkg.sv
// Shared encodings and defaults for the bool_expr sweep sequencer.
// Default widths and vector bit positions are used by the controller and its integrators.
package bool_scan_pkg;
   localparam int NVARS_DEF      = 4;
   localparam int SETTLE_CYC_DEF = 1;

   localparam int A_BIT = 3;
   localparam int B_BIT = 2;
   localparam int C_BIT = 1;
   localparam int D_BIT = 0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } scan_state_e;
endpackage

// File: rtl/bool_expr_scan_ctrl_if.sv
// Host/evaluator signal bundle for bool_expr_scan_ctrl.
// fail_idx_o exists only when BOOL_SCAN_STOP_ON_ERR_EN is defined.
interface bool_expr_scan_ctrl_if #(parameter int NVARS = 4);
   localparam int N = 1 << NVARS;

   logic             start;
   logic [N-1:0]     expected_i;
   logic [NVARS-1:0] vec_o;
   logic             y_i;
   logic             busy_o;
   logic             done_o;
   logic [N-1:0]     table_o;
   logic [NVARS:0]   err_cnt_o;
   logic             mismatch_o;
`ifdef BOOL_SCAN_STOP_ON_ERR_EN
   logic [NVARS-1:0] fail_idx_o;

   modport master (output start, expected_i, y_i,
                   input  vec_o, busy_o, done_o, table_o, err_cnt_o, mismatch_o, fail_idx_o);
   modport slave  (input  start, expected_i, y_i,
                   output vec_o, busy_o, done_o, table_o, err_cnt_o, mismatch_o, fail_idx_o);
`else
   modport master (output start, expected_i, y_i,
                   input  vec_o, busy_o, done_o, table_o, err_cnt_o, mismatch_o);
   modport slave  (input  start, expected_i, y_i,
                   output vec_o, busy_o, done_o, table_o, err_cnt_o, mismatch_o);
`endif
endinterface

// File: rtl/bool_expr_scan_ctrl_settle_cnt.sv
// Loadable settle down-counter; zero is the terminal-count flag.
// Decrement stops at zero so a late dec cannot wrap.
module scan_settle_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/bool_expr_scan_ctrl.sv
// Sweeps all 2^NVARS vectors into an external bool_expr evaluator and scores y.
// Build option BOOL_SCAN_STOP_ON_ERR_EN ends the sweep on the first mismatch.
//
// state    | meaning
// S_IDLE   | vec_o=0, results held, waiting for start
// S_SETTLE | vec_o=idx driven, counting down the settle window
// S_SAMPLE | capture y_i into table_o[idx], score against latched table
// S_DONE   | one-cycle done_o pulse, back to idle
module bool_expr_scan_ctrl
   import bool_scan_pkg::*;
#(
   parameter int NVARS      = NVARS_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input logic                  clk,
   input logic                  rst_n,
   bool_expr_scan_ctrl_if.slave bus
);
   localparam int N  = 1 << NVARS;
   localparam int CW = 4;
   localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE_CYC - 1);
   localparam logic [NVARS-1:0] IDX_LAST  = NVARS'(N - 1);

   scan_state_e      state;
   logic [NVARS-1:0] idx;
   logic [N-1:0]     exp_q;
   logic             accept, advance, y_bad, stop_now;
   logic             cnt_load, cnt_dec, cnt_zero;

   assign accept = (state == S_IDLE) && bus.start;
   assign y_bad  = (bus.y_i != exp_q[idx]);
`ifdef BOOL_SCAN_STOP_ON_ERR_EN
   assign stop_now = y_bad;
`else
   assign stop_now = 1'b0;
`endif
   assign advance  = (state == S_SAMPLE) && (idx != IDX_LAST) && !stop_now;
   assign cnt_load = accept || advance;
   assign cnt_dec  = (state == S_SETTLE);

   scan_settle_cnt #(.W(CW)) u_settle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (SETTLE_LD),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         idx            <= '0;
         exp_q          <= '0;
         bus.vec_o      <= '0;
         bus.busy_o     <= 1'b0;
         bus.done_o     <= 1'b0;
         bus.table_o    <= '0;
         bus.err_cnt_o  <= '0;
         bus.mismatch_o <= 1'b0;
`ifdef BOOL_SCAN_STOP_ON_ERR_EN
         bus.fail_idx_o <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               bus.vec_o <= '0;
               if (bus.start) begin
                  exp_q          <= bus.expected_i;
                  bus.table_o    <= '0;
                  bus.err_cnt_o  <= '0;
                  bus.mismatch_o <= 1'b0;
                  bus.busy_o     <= 1'b1;
                  idx            <= '0;
`ifdef BOOL_SCAN_STOP_ON_ERR_EN
                  bus.fail_idx_o <= '0;
`endif
                  state          <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_zero)
                  state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               bus.table_o[idx] <= bus.y_i;
               if (y_bad) begin
                  bus.err_cnt_o  <= bus.err_cnt_o + 1'b1;
                  bus.mismatch_o <= 1'b1;
               end
               if (advance) begin
                  idx       <= idx + 1'b1;
                  bus.vec_o <= idx + 1'b1;
                  state     <= S_SETTLE;
               end else begin
                  bus.vec_o  <= '0;
                  bus.busy_o <= 1'b0;
                  bus.done_o <= 1'b1;
`ifdef BOOL_SCAN_STOP_ON_ERR_EN
                  if (stop_now)
                     bus.fail_idx_o <= idx;
`endif
                  state      <= S_DONE;
               end
            end
            S_DONE: begin
               bus.done_o <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bool_expr_scan_ctrl.sv
// Scoreboard bench for bool_expr_scan_ctrl: XOR stub at SETTLE_CYC=1, AND-OR stub at SETTLE_CYC=3.
// Honors BOOL_SCAN_STOP_ON_ERR_EN for the stop-on-first-error expectations.
module tb_bool_expr_scan_ctrl;
   import bool_scan_pkg::*;

`ifdef BOOL_SCAN_STOP_ON_ERR_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif

   typedef struct {
      int unsigned acc;
      int unsigned done_edge;
      logic [15:0] tbl;
      int          err;
      int          fidx;
      int          settle;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          passed = 0;
   int          total = 0;
   exp_t        q_a[$];
   exp_t        q_b[$];
   int          vec_bad[2];
   bit          pulse_chk[2];

   bool_expr_scan_ctrl_if #(.NVARS(4)) bus_a ();
   bool_expr_scan_ctrl_if #(.NVARS(4)) bus_b ();

   bool_expr_scan_ctrl #(.NVARS(4), .SETTLE_CYC(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   bool_expr_scan_ctrl #(.NVARS(4), .SETTLE_CYC(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   // a: y = a^b^c^d ; b: y = (a&b) | (~c&d), truth table 16'hF222
   assign bus_a.y_i = bus_a.vec_o[A_BIT] ^ bus_a.vec_o[B_BIT] ^ bus_a.vec_o[C_BIT] ^ bus_a.vec_o[D_BIT];
   assign bus_b.y_i = (bus_b.vec_o[A_BIT] & bus_b.vec_o[B_BIT]) | (~bus_b.vec_o[C_BIT] & bus_b.vec_o[D_BIT]);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic mon_step(input int w, input logic busy, input logic done, input logic [3:0] vec,
                           input logic [15:0] tbl, input logic [4:0] err, input logic mm);
      exp_t  e;
      bit    have;
      string p;
      int    t;
      p    = (w == 0) ? "a" : "b";
      have = (w == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
      if (have) begin
         if (w == 0) e = q_a[0];
         else        e = q_b[0];
      end
      if (pulse_chk[w]) begin
         check({p, "_done_pulse_width"}, 32'(done), 32'd0);
         pulse_chk[w] = 1'b0;
      end else if (done) begin
         if (!have) begin
            check({p, "_unexpected_done"}, 32'd1, 32'd0);
         end else begin
            if (w == 0) void'(q_a.pop_front());
            else        void'(q_b.pop_front());
            check({p, "_done_cycle"}, cyc, e.done_edge);
            check({p, "_table"}, 32'(tbl), 32'(e.tbl));
            check({p, "_err_cnt"}, 32'(err), e.err);
            check({p, "_mismatch"}, 32'(mm), 32'(e.err != 0));
            check({p, "_busy_in_done"}, 32'(busy), 32'd0);
            check({p, "_vec_in_done"}, 32'(vec), 32'd0);
            check({p, "_vec_sequence_errs"}, vec_bad[w], 32'd0);
`ifdef BOOL_SCAN_STOP_ON_ERR_EN
            check({p, "_fail_idx"}, 32'((w == 0) ? bus_a.fail_idx_o : bus_b.fail_idx_o), e.fidx);
`endif
            pulse_chk[w] = 1'b1;
         end
         vec_bad[w] = 0;
      end else if (busy && have && cyc >= e.acc) begin
         t = int'(cyc - e.acc);
         if (vec != 4'(t / (e.settle + 1))) vec_bad[w]++;
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         vec_bad[0] = 0; vec_bad[1] = 0;
         pulse_chk[0] = 1'b0; pulse_chk[1] = 1'b0;
      end else begin
         mon_step(0, bus_a.busy_o, bus_a.done_o, bus_a.vec_o, bus_a.table_o, bus_a.err_cnt_o, bus_a.mismatch_o);
         mon_step(1, bus_b.busy_o, bus_b.done_o, bus_b.vec_o, bus_b.table_o, bus_b.err_cnt_o, bus_b.mismatch_o);
      end
   end

   task automatic push_exp(input int w, input int unsigned acc, input logic [15:0] tbl,
                           input int err, input int fidx, input int nedges);
      exp_t e;
      e.acc = acc; e.done_edge = acc + nedges; e.tbl = tbl;
      e.err = err; e.fidx = fidx; e.settle = (w == 0) ? 1 : 3;
      if (w == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   // call at a negedge: raises start so the next posedge is the accept edge
   task automatic issue(input int w, input logic [15:0] ex, input logic [15:0] tbl,
                        input int err, input int fidx, input int nedges, output int unsigned acc);
      acc = cyc + 1;
      push_exp(w, acc, tbl, err, fidx, nedges);
      if (w == 0) begin bus_a.expected_i = ex; bus_a.start = 1'b1; end
      else        begin bus_b.expected_i = ex; bus_b.start = 1'b1; end
   endtask

   task automatic wait_drain(input int w);
      int sz;
      for (int i = 0; i < 300; i++) begin
         sz = (w == 0) ? q_a.size() : q_b.size();
         if (sz == 0) break;
         @(negedge clk);
      end
      sz = (w == 0) ? q_a.size() : q_b.size();
      check((w == 0) ? "a_sweep_drained" : "b_sweep_drained", sz, 32'd0);
      if (w == 0) q_a.delete();
      else        q_b.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic sweep(input int w, input logic [15:0] ex, input logic [15:0] tbl,
                        input int err, input int fidx, input int nedges);
      int unsigned acc;
      @(negedge clk);
      issue(w, ex, tbl, err, fidx, nedges, acc);
      @(negedge clk);
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      wait_drain(w);
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_busy"}, 32'(bus_a.busy_o), 32'd0);
      check({tag, "_done"}, 32'(bus_a.done_o), 32'd0);
      check({tag, "_vec"}, 32'(bus_a.vec_o), 32'd0);
      check({tag, "_table"}, 32'(bus_a.table_o), 32'd0);
      check({tag, "_err_cnt"}, 32'(bus_a.err_cnt_o), 32'd0);
      check({tag, "_mismatch"}, 32'(bus_a.mismatch_o), 32'd0);
`ifdef BOOL_SCAN_STOP_ON_ERR_EN
      check({tag, "_fail_idx"}, 32'(bus_a.fail_idx_o), 32'd0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before 500000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned acc0;
      bus_a.start = 1'b0; bus_a.expected_i = '0;
      bus_b.start = 1'b0; bus_b.expected_i = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_a_zero("reset");

      // XOR stub, settle 1: full sweep = 32 edges after accept (done in cycle 33)
      sweep(0, 16'h6996, 16'h6996, 0, 0, 32);
      sweep(0, 16'h6997, STOP_EN ? 16'h0000 : 16'h6996, 1, 0, STOP_EN ? 2 : 32);
      sweep(0, 16'h0000, STOP_EN ? 16'h0002 : 16'h6996, STOP_EN ? 1 : 8, 1, STOP_EN ? 4 : 32);
      sweep(0, 16'h6992, STOP_EN ? 16'h0006 : 16'h6996, 1, 2, STOP_EN ? 6 : 32);

      // AND-OR stub, settle 3: 64 edges (done in cycle 65)
      sweep(1, 16'hF222, 16'hF222, 0, 0, 64);
      sweep(1, 16'h0000, STOP_EN ? 16'h0002 : 16'hF222, STOP_EN ? 1 : 7, 1, STOP_EN ? 8 : 64);

      // second start and expected_i change mid-sweep must be ignored
      @(negedge clk);
      issue(0, 16'h6996, 16'h6996, 0, 0, 32, acc0);
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (9) @(negedge clk);
      bus_a.expected_i = 16'h0000;
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      wait_drain(0);

      // start held: second accept lands one cycle after DONE
      @(negedge clk);
      issue(0, 16'h6996, 16'h6996, 0, 0, 32, acc0);
      push_exp(0, acc0 + 34, 16'h6996, 0, 0, 32);
      for (int i = 0; i < 100 && cyc < acc0 + 34; i++) @(negedge clk);
      bus_a.start = 1'b0;
      wait_drain(0);

      // reset mid-sweep: async clear, no done pulse, then a clean sweep
      @(negedge clk);
      bus_a.expected_i = 16'h6996;
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (11) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_a_zero("async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sweep(0, 16'h6996, 16'h6996, 0, 0, 32);

      check("a_queue_empty", q_a.size(), 32'd0);
      check("b_queue_empty", q_b.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
